// File: rtl/esc_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : esc_pwm_pkg
//  Description : Shared types and constants for the ESC PWM guard.
//                FSM state encodings, the 20-bit pulse-width type, the
//                throttle ceiling and the throttle-to-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package esc_pwm_pkg;

    // State encodings, also used by anyone observing the 2-bit state port
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_RAMP = 2'd2;
    localparam logic [1:0] c_ST_SAFE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_RAMP = c_ST_RAMP,
        ST_SAFE = c_ST_SAFE
    } state_t;

    // Pulse widths and the frame counter share one 20-bit unsigned type
    typedef logic [19:0] width_t;

    localparam int c_THR_MAX = 1000;

    // Clamp a raw 10-bit throttle to the ceiling and convert to cycles
    function automatic width_t thr_to_width(input logic [9:0] thr,
                                            input int         pw_min,
                                            input int         step_cyc);
        logic [9:0] v_thr;
        v_thr = (thr > 10'(c_THR_MAX)) ? 10'(c_THR_MAX) : thr;
        return width_t'(pw_min) + width_t'(v_thr) * width_t'(step_cyc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/esc_pwm_guard_stop_filter.sv
`default_nettype none
// ============================================================================
//  Module      : esc_pwm_guard_stop_filter
//  Description : Debounce for the security block's stop level. stop must be
//                high for STOP_FILT consecutive cycles; any low cycle clears
//                the count. Produces a one-cycle detect pulse and a level.
//  Ports       : clk, reset_n (async, active-low), stop (raw level),
//                stop_det (1-cycle pulse on acceptance),
//                stop_level (high while the accepted stop persists)
//  Revision    : 1.0 - initial release
// ============================================================================
module esc_pwm_guard_stop_filter #(
    parameter int STOP_FILT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stop,
    output logic stop_det,
    output logic stop_level
);

    localparam int               c_CW   = $clog2(STOP_FILT + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(STOP_FILT - 1);
    localparam logic [c_CW-1:0]  c_SAT  = c_CW'(STOP_FILT);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic            r_det;
    logic            r_level;
    logic            w_hit;

    // The STOP_FILT-th consecutive high sample
    assign w_hit = stop && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_det   <= 1'b0;
            r_level <= 1'b0;
        end else begin
            if (!stop)
                r_cnt <= '0;
            else if (r_cnt != c_SAT)
                r_cnt <= r_cnt + c_ONE;
            r_det   <= w_hit;
            r_level <= stop && (r_cnt >= c_LAST);
        end
    end

    assign stop_det   = r_det;
    assign stop_level = r_level;

endmodule
`default_nettype wire

// File: rtl/esc_pwm_guard.sv
`default_nettype none
// ============================================================================
//  Module      : esc_pwm_guard
//  Description : Final ESC drive stage. Generates one servo-PWM frame per
//                FRAME_CYC cycles for each motor, with pulse width taken
//                from the throttle command. A filtered stop request ramps
//                all motors to the idle pulse and latches a safe state
//                that needs two arm strobes (SAFE->IDLE->RUN) to leave.
//  Ports       : clk, reset_n (async, active-low)
//                stop            stop request level from security block
//                arm             single-cycle re-arm strobe
//                throttle        NUM_CH x 10-bit throttles (0..1000)
//                throttle_valid  single-cycle sample strobe for throttle
//                pwm_out         registered ESC pulse outputs
//                state           FSM state (IDLE=0 RUN=1 RAMP=2 SAFE=3)
//                stop_latched    high in RAMP and SAFE
//  Build option: STOP_HARD_CUT_EN - stop goes straight to SAFE and SAFE
//                drives no pulses at all.
//  Revision    : 1.0 - initial release
// ============================================================================
module esc_pwm_guard
    import esc_pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int FRAME_CYC = 1000000,
    parameter int PW_MIN    = 50000,
    parameter int STEP_CYC  = 50,
    parameter int STOP_FILT = 4,
    parameter int RAMP_STEP = 500
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stop,
    input  logic                 arm,
    input  logic [NUM_CH*10-1:0] throttle,
    input  logic                 throttle_valid,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [1:0]           state,
    output logic                 stop_latched
);

    localparam width_t c_PW_MIN     = width_t'(PW_MIN);
    localparam width_t c_FRAME_LAST = width_t'(FRAME_CYC - 1);
    localparam width_t c_RAMP       = width_t'(RAMP_STEP);
    localparam width_t c_RAMP_FLOOR = width_t'(PW_MIN + RAMP_STEP);

    state_t             r_state;
    state_t             w_next;
    width_t             r_frame_cnt;
    width_t             r_shadow [NUM_CH];
    width_t             r_active [NUM_CH];
    width_t             w_thr_width [NUM_CH];
    logic [NUM_CH-1:0]  r_pwm;
    logic               w_boundary;
    logic               w_active_min;
    logic               w_shadow_min;
    logic               w_pwm_en;
    logic               w_stop_det;
    logic               w_stop_level;

    esc_pwm_guard_stop_filter #(
        .STOP_FILT (STOP_FILT)
    ) u_stop_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .stop       (stop),
        .stop_det   (w_stop_det),
        .stop_level (w_stop_level)
    );

    // ------------------------------------------------------------------
    // Frame counter: 0..FRAME_CYC-1; count 0 is the frame boundary
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_frame_cnt <= '0;
        else if (r_frame_cnt == c_FRAME_LAST)
            r_frame_cnt <= '0;
        else
            r_frame_cnt <= r_frame_cnt + width_t'(1);
    end

    assign w_boundary = (r_frame_cnt == '0);

    // ------------------------------------------------------------------
    // Per-channel throttle decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_thr
        assign w_thr_width[gi] = thr_to_width(throttle[10*gi +: 10], PW_MIN, STEP_CYC);
    end

    always_comb begin
        w_active_min = 1'b1;
        w_shadow_min = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_active[i] != c_PW_MIN) w_active_min = 1'b0;
            if (r_shadow[i] != c_PW_MIN) w_shadow_min = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active widths. Active only changes at the boundary in
    // RUN/RAMP so a pulse in flight is never shortened or stretched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= c_PW_MIN;
                r_active[i] <= c_PW_MIN;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Commands are frozen during the ramp so it cannot be undone
                if (throttle_valid && (r_state != ST_RAMP))
                    r_shadow[i] <= w_thr_width[i];

                case (r_state)
                    ST_RUN: begin
                        if (w_boundary)
                            r_active[i] <= r_shadow[i];
                    end
                    ST_RAMP: begin
                        if (w_boundary)
                            r_active[i] <= (r_active[i] >= c_RAMP_FLOOR) ?
                                           (r_active[i] - c_RAMP) : c_PW_MIN;
                    end
                    default: r_active[i] <= c_PW_MIN;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse generation
    // ------------------------------------------------------------------
`ifdef STOP_HARD_CUT_EN
    assign w_pwm_en = (r_state != ST_SAFE);
`else
    assign w_pwm_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                r_pwm[i] <= w_pwm_en && (r_frame_cnt < r_active[i]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // stop wins over a simultaneous arm
                if (w_stop_det)
                    w_next = ST_SAFE;
                else if (arm && !w_stop_level && w_shadow_min)
                    w_next = ST_RUN;
            end
            ST_RUN: begin
`ifdef STOP_HARD_CUT_EN
                if (w_stop_det) w_next = ST_SAFE;
`else
                if (w_stop_det) w_next = ST_RAMP;
`endif
            end
            ST_RAMP: begin
                if (w_boundary && w_active_min)
                    w_next = ST_SAFE;
            end
            ST_SAFE: begin
                // Re-arm lands in IDLE; a second arm is needed to run
                if (arm && !w_stop_det && !w_stop_level)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign pwm_out      = r_pwm;
    assign state        = r_state;
    assign stop_latched = (r_state == ST_RAMP) || (r_state == ST_SAFE);

endmodule
`default_nettype wire
